// File: rtl/data_memory.sv
// Single-port word-addressed data memory for the single-cycle CPU datapath.
// Writes and synchronous clear happen on the falling clock edge; reads are combinational.
module data_memory #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int DEPTH  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ena,
  input  logic              wena,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] data_out
);

  // Every address value maps to a real word, so no range or wrap logic is needed.
  if (DEPTH != (1 << ADDR_W)) begin : g_depth_check
    $error("data_memory: DEPTH must equal 2**ADDR_W");
  end

  logic [DATA_W-1:0] mem [DEPTH];

  logic do_write;
  logic do_read;

  assign do_write = ena & wena;
  assign do_read  = ena & ~wena;

  // Falling-edge update lets a store issued early in the CPU cycle land inside that cycle.
  // NOTE: a whole-array clear forces the storage into flops rather than a RAM macro;
  // that is intended here, and rst is checked first so it discards a coincident write.
  always_ff @(negedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (do_write) begin
      // NOTE: non-blocking keeps the array update ordered after every read of this edge.
      mem[addr] <= data_in;
    end
  end

  // Zero during write cycles and when disabled, so the bus never shows stale contents.
  assign data_out = do_read ? mem[addr] : '0;

endmodule

// File: tb/tb_data_memory.sv
// Randomised scoreboard bench for data_memory: stimulus pushes expected data_out,
// a monitor pops and compares once per cycle at the rising edge.
module tb_data_memory;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int DEPTH  = 32;

  logic              clk;
  logic              rst;
  logic              ena;
  logic              wena;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] data_in;
  logic [DATA_W-1:0] data_out;

  data_memory #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk     (clk),
    .rst     (rst),
    .ena     (ena),
    .wena    (wena),
    .addr    (addr),
    .data_in (data_in),
    .data_out(data_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [DATA_W-1:0] exp;
    string             name;
  } sb_entry_t;

  sb_entry_t         sb [$];
  logic [DATA_W-1:0] model [DEPTH];
  int                checks = 0;
  int                errors = 0;

  task automatic check(input string name, input logic [DATA_W-1:0] act,
                       input logic [DATA_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: data_out=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: data_out sampled at the rising edge, opposite the falling update edge.
  initial begin
    sb_entry_t e;
    forever begin
      @(posedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check(e.name, data_out, e.exp);
      end
    end
  end

  // One CPU cycle: drive after the rising edge, predict the combinational read
  // from pre-edge contents, then apply the falling-edge effect to the model.
  task automatic cycle(input string name, input logic r, input logic en,
                       input logic we, input logic [ADDR_W-1:0] a,
                       input logic [DATA_W-1:0] d);
    sb_entry_t e;
    @(posedge clk);
    #1;
    rst = r; ena = en; wena = we; addr = a; data_in = d;
    e.name = name;
    e.exp  = (en && !we) ? model[a] : '0;
    sb.push_back(e);
    if (r) begin
      for (int i = 0; i < DEPTH; i++) model[i] = '0;
    end else if (en && we) begin
      model[a] = d;
    end
  endtask

  task automatic rd(input string name, input logic [ADDR_W-1:0] a);
    cycle(name, 1'b0, 1'b1, 1'b0, a, $urandom);
  endtask

  task automatic wr(input string name, input logic [ADDR_W-1:0] a,
                    input logic [DATA_W-1:0] d);
    cycle(name, 1'b0, 1'b1, 1'b1, a, d);
  endtask

  // Read cycle whose wena is raised after the falling edge and held across the
  // next rising edge only; the memory must ignore it.
  task automatic rise_only_pulse(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    sb_entry_t e;
    @(posedge clk);
    #1;
    rst = 1'b0; ena = 1'b1; wena = 1'b0; addr = a; data_in = '0;
    e.name = "rise_pulse_bus";
    e.exp  = '0;
    sb.push_back(e);
    @(negedge clk);
    #1;
    wena = 1'b1; data_in = d; addr = a;
  endtask

  initial begin : stimulus
    logic [ADDR_W-1:0] ra;
    logic [DATA_W-1:0] rdat;
    int                op;
    rst = 1'b0; ena = 1'b0; wena = 1'b0; addr = '0; data_in = '0;
    for (int i = 0; i < DEPTH; i++) model[i] = '0;

    // Reset clear
    cycle("reset_bus", 1'b1, 1'b0, 1'b0, '0, '0);
    rd("reset_rd0", 5'd0);
    rd("reset_rd5", 5'd5);
    rd("reset_rd31", 5'd31);

    // Basic write/read
    wr("basic_wr_bus", 5'd0, 32'hffff0000);
    rd("basic_rd0", 5'd0);
    rd("basic_rd1", 5'd1);

    // Enable gating
    cycle("gate_wr_bus", 1'b0, 1'b0, 1'b1, 5'd3, 32'h12345678);
    rd("gate_rd3", 5'd3);
    cycle("gate_off_rd0", 1'b0, 1'b0, 1'b0, 5'd0, '0);

    // Edge sensitivity
    rise_only_pulse(5'd9, 32'hCAFEF00D);
    rd("edge_rd9", 5'd9);
    rise_only_pulse(5'd0, 32'h0BADBEEF);
    rd("edge_rd0", 5'd0);
    wr("edge_wr31_bus", 5'd31, 32'hA5A5A5A5);
    rd("edge_rd31", 5'd31);

    // Reset priority mid-operation
    wr("prio_wr7_bus", 5'd7, 32'hDEADBEEF);
    rd("prio_pre_rd7", 5'd7);
    cycle("prio_rst_wr_bus", 1'b1, 1'b1, 1'b1, 5'd7, 32'h11111111);
    for (int i = 0; i < DEPTH; i++) rd($sformatf("prio_post_rd%0d", i), ADDR_W'(i));

    // Full sweep
    for (int i = 0; i < DEPTH; i++) wr("sweep_wr_bus", ADDR_W'(i), 32'(i) * 32'h01010101);
    for (int i = 0; i < DEPTH; i++) rd($sformatf("sweep_rd%0d", i), ADDR_W'(i));
    wr("overwrite_bus", 5'd0, 32'h0000FFFF);
    for (int i = 0; i < DEPTH; i++) rd($sformatf("overwrite_rd%0d", i), ADDR_W'(i));

    // Randomised traffic, including occasional resets and disabled cycles
    for (int n = 0; n < 400; n++) begin
      op   = int'($urandom_range(0, 99));
      ra   = ADDR_W'($urandom);
      rdat = $urandom;
      if (op < 2)       cycle("rand_rst_bus", 1'b1, op[0], 1'b1, ra, rdat);
      else if (op < 40) wr("rand_wr_bus", ra, rdat);
      else if (op < 50) cycle("rand_off", 1'b0, 1'b0, op[0], ra, rdat);
      else              rd("rand_rd", ra);
    end

    // Drain the scoreboard with a bounded wait.
    for (int k = 0; k < 10 && sb.size() > 0; k++) @(posedge clk);
    if (sb.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d entries left, expected 0", sb.size());
    end
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
